// File: rtl/iob_gpio_disp_pkg.sv
// Shared definitions for the GPIO 4-digit 7-segment scan controller:
// FSM encodings, blanking constants and the hex-to-segment table.
package iob_gpio_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low segments {g,f,e,d,c,b,a}, indexed by hex digit value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [3:0] an_select(input logic [1:0] digit);
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/iob_gpio_hex2seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module iob_gpio_hex2seg
    import iob_gpio_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/iob_gpio_disp_scan.sv
// Time-multiplexed 4-digit 7-segment scan controller with frame-aligned value commit.
// Optional leading-zero blanking is enabled by defining IOB_GPIO_DISP_LZB_EN.
module iob_gpio_disp_scan
    import iob_gpio_disp_pkg::*;
#(
    parameter int DIGIT_TICKS = 50000,
    parameter int BLANK_TICKS = 500,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic [15:0] value_i,
    input  logic        value_valid_i,
    output logic        value_ready_o,
    output logic [3:0]  disp_an_o,
    output logic [6:0]  disp_ca_o,
    output logic        frame_o
);

    localparam logic [CNT_W-1:0] DIGIT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST  = (BLANK_TICKS > 0) ? CNT_W'(BLANK_TICKS - 1) : '0;
    localparam scan_state_e      DIGIT_ENTRY = (BLANK_TICKS > 0) ? BLANK : SHOW;

    scan_state_e      state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [1:0]       digit_r, digit_n;
    logic [15:0]      display_r, display_n;
    logic [15:0]      pend_val_r, pend_val_n;
    logic             pend_full_r, pend_full_n;
    logic             accept_s, boundary_s, commit_s;
    logic [3:0]       nibble_s;
    logic [6:0]       seg_s;
    logic             lead_zero_s;
    logic [3:0]       an_n;
    logic [6:0]       ca_n;

    assign accept_s   = value_valid_i && value_ready_o;
    assign boundary_s = en_i && (state_r == SHOW) && (digit_r == 2'd3) && (cnt_r == DIGIT_LAST);
    // Commits happen only at a frame boundary or while idle, so a frame never tears.
    assign commit_s   = pend_full_r && ((state_r == IDLE) || boundary_s);

    // Pending buffer and display register update.
    always_comb begin
        display_n   = display_r;
        pend_val_n  = pend_val_r;
        pend_full_n = pend_full_r;
        if (commit_s) begin
            display_n   = pend_val_r;
            pend_full_n = 1'b0;
        end else if (accept_s) begin
            pend_val_n  = value_i;
            pend_full_n = 1'b1;
        end else begin
            pend_full_n = pend_full_r;
        end
    end

    // Scan FSM next-state, tick counter and digit index.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        digit_n = digit_r;
        if (!en_i) begin
            state_n = IDLE;
            cnt_n   = '0;
            digit_n = 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = DIGIT_ENTRY;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                end
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_n = SHOW;
                        cnt_n   = '0;
                    end else begin
                        cnt_n   = cnt_r + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_r == DIGIT_LAST) begin
                        state_n = DIGIT_ENTRY;
                        cnt_n   = '0;
                        digit_n = digit_r + 2'd1;
                    end else begin
                        cnt_n   = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    digit_n = 2'd0;
                end
            endcase
        end
    end

    // Decode looks ahead at the next digit and display so outputs stay aligned with the state.
    assign nibble_s = display_n[{digit_n, 2'b00} +: 4];

    iob_gpio_hex2seg u_hex2seg (
        .nibble (nibble_s),
        .seg    (seg_s)
    );

`ifdef IOB_GPIO_DISP_LZB_EN
    // Blank a digit when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        lead_zero_s = 1'b0;
        case (digit_n)
            2'd1:    lead_zero_s = (display_n[15:4]  == 12'h000);
            2'd2:    lead_zero_s = (display_n[15:8]  == 8'h00);
            2'd3:    lead_zero_s = (display_n[15:12] == 4'h0);
            default: lead_zero_s = 1'b0;
        endcase
    end
`else
    assign lead_zero_s = 1'b0;
`endif

    // Anode and cathode values for the cycle after the next edge.
    always_comb begin
        an_n = AN_OFF;
        ca_n = SEG_BLANK;
        if (state_n == SHOW) begin
            an_n = an_select(digit_n);
            if (lead_zero_s) begin
                ca_n = SEG_BLANK;
            end else begin
                ca_n = seg_s;
            end
        end else begin
            an_n = AN_OFF;
            ca_n = SEG_BLANK;
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            digit_r       <= 2'd0;
            display_r     <= 16'h0000;
            pend_val_r    <= 16'h0000;
            pend_full_r   <= 1'b0;
            value_ready_o <= 1'b1;
            disp_an_o     <= AN_OFF;
            disp_ca_o     <= SEG_BLANK;
            frame_o       <= 1'b0;
        end else begin
            state_r       <= state_n;
            cnt_r         <= cnt_n;
            digit_r       <= digit_n;
            display_r     <= display_n;
            pend_val_r    <= pend_val_n;
            pend_full_r   <= pend_full_n;
            value_ready_o <= ~pend_full_n;
            disp_an_o     <= an_n;
            disp_ca_o     <= ca_n;
            frame_o       <= boundary_s;
        end
    end

endmodule

// File: tb/tb_iob_gpio_disp_scan.sv
// Scoreboard bench for iob_gpio_disp_scan (DIGIT_TICKS=4, BLANK_TICKS=2); follows
// IOB_GPIO_DISP_LZB_EN when defined.
module tb_iob_gpio_disp_scan;

    localparam int DT    = 4;
    localparam int BT    = 2;
    localparam int SLOT  = DT + BT;
    localparam int FRAME = 4 * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] ca;
        logic       rdy;
        logic       frm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic [15:0] value_i = 16'h0000;
    logic        value_valid_i = 1'b0;
    logic        value_ready_o;
    logic [3:0]  disp_an_o;
    logic [6:0]  disp_ca_o;
    logic        frame_o;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    iob_gpio_disp_scan #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .value_i       (value_i),
        .value_valid_i (value_valid_i),
        .value_ready_o (value_ready_o),
        .disp_an_o     (disp_an_o),
        .disp_ca_o     (disp_ca_o),
        .frame_o       (frame_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Reference model: scan position is just elapsed cycles since enable, modulo the frame.
    initial begin : model
        logic        run;
        int          t;
        logic [15:0] disp, pval;
        logic        pfull, boundary, commit, accept;
        int          p, d;
        exp_t        e;
        run = 1'b0; t = 0; disp = 16'h0000; pval = 16'h0000; pfull = 1'b0;
        forever begin
            @(posedge clk);
            if (rst) begin
                run = 1'b0; t = 0; disp = 16'h0000; pfull = 1'b0;
                e = '{an: 4'hF, ca: 7'h7F, rdy: 1'b1, frm: 1'b0};
            end else begin
                boundary = run && en_i && ((t % FRAME) == FRAME - 1);
                commit   = pfull && (!run || boundary);
                accept   = value_valid_i && !pfull;
                if (commit) begin
                    disp  = pval;
                    pfull = 1'b0;
                end else if (accept) begin
                    pval  = value_i;
                    pfull = 1'b1;
                end
                if (!en_i) begin
                    run = 1'b0; t = 0;
                end else if (!run) begin
                    run = 1'b1; t = 0;
                end else begin
                    t++;
                end
                e = '{an: 4'hF, ca: 7'h7F, rdy: !pfull, frm: boundary};
                if (run) begin
                    p = t % FRAME;
                    d = p / SLOT;
                    if ((p % SLOT) >= BT) begin
                        e.an = ~(4'b0001 << d);
                        e.ca = ref_seg(disp[4*d +: 4]);
`ifdef IOB_GPIO_DISP_LZB_EN
                        if (d >= 1 && (disp >> (4 * d)) == 16'h0000) e.ca = 7'h7F;
`endif
                    end
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare each cycle's outputs against the queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("disp_an", int'(disp_an_o), int'(e.an));
                chk("disp_ca", int'(disp_ca_o), int'(e.ca));
                chk("ready",   int'(value_ready_o), int'(e.rdy));
                chk("frame",   int'(frame_o), int'(e.frm));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        int n;
        n = 0;
        value_i = v;
        value_valid_i = 1'b1;
        while (!value_ready_o && n < 500) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL send_timeout: ready still %0b after %0d cycles, required 1", value_ready_o, n);
        end
        tick(1);
        value_valid_i = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] an);
        int n;
        n = 0;
        while (disp_an_o !== an && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_an: an=%h after %0d cycles, required %h", disp_an_o, n, an);
        end
    endtask

    initial begin : stimulus
        tick(3);
        rst = 1'b0;
        tick(20);                       // idle with en low

        send(16'h1234);
        tick(2);
        en_i = 1'b1;
        tick(60);

        tick(7);                        // mid-frame update
        send(16'hABCD);
        tick(60);

        send(16'h5678);                 // back-to-back, second stalls
        send(16'h9EF0);
        tick(60);

        wait_an(4'hB);                  // disable during digit 2
        en_i = 1'b0;
        tick(5);
        en_i = 1'b1;
        tick(40);
        wait_an(4'hB);                  // reset during digit 2
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);

        send(16'h0050);
        tick(60);
        send(16'h0000);
        tick(60);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) en_i = ~en_i;
            if (!en_i && $urandom_range(0, 19) == 0) en_i = 1'b1;
            value_valid_i = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       value_i = 16'h0050;
                1:       value_i = 16'h0000;
                default: value_i = 16'($urandom);
            endcase
            tick(1);
        end
        value_valid_i = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iob_gpio_disp_scan.md
Name: iob_gpio_disp_scan

Overview:
- Time-multiplexed scan controller for the 4-digit, 7-segment display pins driven by the GPIO peripheral (disp_an[3:0], disp_ca[6:0]).
- Accepts a 16-bit hex value over a valid/ready handshake, buffers it, and applies it only at frame boundaries, so the display never tears.
- Steps through the four digits with a programmable dwell time and an inter-digit blanking gap for anti-ghosting.
- Replaces direct CPU bit-banging of the anode and cathode registers.

Parameters:
- DIGIT_TICKS, 50000: clk cycles each digit is lit; must be >= 1.
- BLANK_TICKS, 500: clk cycles all anodes are off before each digit; 0 skips the blank phase.
- CNT_W, 16: tick counter width; must hold max(DIGIT_TICKS, BLANK_TICKS) - 1.

Ports:
- clk  in  1: system clock.
- rst  in  1: asynchronous reset, active-high.
- en_i  in  1: scan enable.
- value_i  in  16: four hex digits; digit i = value_i[4i+3:4i]; digit 0 is rightmost.
- value_valid_i  in  1: value_i is valid.
- value_ready_o  out  1: pending buffer is empty; a value is accepted when valid && ready.
- disp_an_o  out  4: anode selects, active-low.
- disp_ca_o  out  7: segments {g,f,e,d,c,b,a}, active-low.
- frame_o  out  1: one-cycle pulse at the end of each digit-3 SHOW phase.

Behaviour:
- Reset values:
  - disp_an_o=4'hF, disp_ca_o=7'h7F, value_ready_o=1, frame_o=0.
  - State IDLE, digit index 0, tick counter 0.
  - Display register 16'h0000, pending buffer empty.
- All outputs are registered. Reset asserted mid-scan forces reset values on the next edge with no wait.
- FSM states:
  - IDLE: outputs blanked (an=F, ca=7F). When en_i=1, go to BLANK with digit 0, or straight to SHOW if BLANK_TICKS=0.
  - BLANK: an=F, ca=7F for BLANK_TICKS cycles, then go to SHOW.
  - SHOW: an has bit[digit]=0 and all other bits 1; ca = decode of the display register nibble. Lasts DIGIT_TICKS cycles.
  - At the end of SHOW, digit increments mod 4 (3 wraps to 0) and the FSM goes to BLANK, or SHOW if BLANK_TICKS=0.
- Tick counter: cleared on every state entry; the state exits when count = TICKS-1.
- en_i=0 in any state: next cycle is IDLE with outputs blanked; counter and digit cleared. The pending buffer is kept.
- Handshake:
  - The pending buffer is one entry deep; value_ready_o = ~pending_full.
  - Accept when value_valid_i && value_ready_o; pending_full sets on the next edge.
  - value_i is sampled only on the accept edge.
- Commit:
  - At a frame boundary (last SHOW cycle of digit 3), a full pending buffer transfers to the display register. pending_full clears and ready rises on the next cycle.
  - frame_o pulses on that same edge.
  - In IDLE, a full pending buffer commits on the next edge with no frame wait.
- Simultaneous events: an accept in a frame-boundary cycle (buffer was empty) lands in pending and commits at the following frame. Two commits never occur within one frame.
- Decode is standard hex 0-F, e.g. 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.

Optional Feature:
- Macro: IOB_GPIO_DISP_LZB_EN (leading-zero blanking).
- Defined: during SHOW of digit i (i >= 1), ca=7'h7F if every nibble from i up to 3 is 0. Digit 0 always shows, so value 0 shows a single "0". Anode timing is unchanged.
- Undefined: all four digits always show, including leading zeros.

Decomposition:
- Package iob_gpio_disp_pkg holds:
  - FSM state encodings IDLE=2'd0, BLANK=2'd1, SHOW=2'd2.
  - SEG_BLANK=7'h7F, AN_OFF=4'hF.
  - The 16-entry hex-to-segment constant table.
- Sub-module iob_gpio_hex2seg: combinational 4-bit to 7-bit active-low decoder. It is instantiated once, on the mux-selected nibble.

Test Plan:
All scenarios use DIGIT_TICKS=4, BLANK_TICKS=2.
1. Reset, hold en_i=0 for 20 cycles -> an=F, ca=7F, ready=1, frame_o never pulses.
2. Accept 16'h1234, then set en_i=1:
   - Value commits from IDLE; period is 6 cycles per digit.
   - Digit 0: an=E, ca=0x19 ("4") for 4 cycles, preceded by 2 blank cycles.
   - Digits 1-3 follow with an=D/B/7 showing 3/2/1.
   - frame_o pulses once every 24 cycles.
3. While scanning 16'h1234, accept 16'hABCD mid-frame:
   - ready drops for the rest of the frame.
   - Digits keep 1234 until the frame_o edge, then the next frame shows D,C,B,A.
   - ready returns to 1 after the commit.
4. Hold valid with two back-to-back values -> the second is stalled (ready=0) until the commit. Exactly one commit per frame.
5. Deassert en_i mid-SHOW of digit 2 -> next cycle an=F; re-enable -> scan restarts at digit 0 with a BLANK phase. Assert rst mid-SHOW -> reset values on the next edge.
6. With IOB_GPIO_DISP_LZB_EN defined, value 16'h0050 -> digits 3 and 2 show ca=7F, digit 1 shows "5" (0x12), digit 0 shows "0" (0x40). Value 16'h0000 -> only digit 0 lit, showing "0".
